// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 keyboard frame receiver with E0/F0 prefix handling and
//               a table of tracked key-held bits.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int                    NUM_KEYS       = 8,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h172, 9'h174, 9'h16B, 9'h175,
                                                       9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int                    TIMEOUT_CYCLES = 50000,
    parameter bit                    ACTIVE_LOW     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic                ev_valid,
    output logic [7:0]          ev_code,
    output logic                ev_ext,
    output logic                ev_break,
    output logic                frame_err,
    output logic [NUM_KEYS-1:0] keys
);

    localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;
    state_t          r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext, r_brk;
    logic            w_fall;
    logic            w_timeout;
    logic            w_frame_ok;

    // Lines idle high, so synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall     = r_clk_prev & ~r_clk_s2;
    assign w_timeout  = (r_to_cnt == TO_MAX);
    assign w_frame_ok = r_dat_s2 & (^{r_shift, r_parity});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            ev_valid  <= 1'b0;
            ev_code   <= 8'd0;
            ev_ext    <= 1'b0;
            ev_break  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ev_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (w_timeout) begin
                // Timeout wins over a coincident edge, which is dropped.
                r_state   <= S_IDLE;
                r_bit_cnt <= 3'd0;
                r_to_cnt  <= '0;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                if (w_fall || r_state == S_IDLE) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
                if (w_fall) begin
                    case (r_state)
                        S_IDLE: begin
                            if (!r_dat_s2) begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= 3'd0;
                            end
                        end
                        S_DATA: begin
                            r_shift   <= {r_dat_s2, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_PARITY;
                            end
                        end
                        S_PARITY: begin
                            r_parity <= r_dat_s2;
                            r_state  <= S_STOP;
                        end
                        S_STOP: begin
                            r_state <= S_IDLE;
                            if (!w_frame_ok) begin
                                frame_err <= 1'b1;
                                r_ext     <= 1'b0;
                                r_brk     <= 1'b0;
                            end else if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else begin
                                ev_valid <= 1'b1;
                                ev_code  <= r_shift;
                                ev_ext   <= r_ext;
                                ev_break <= r_brk;
                                r_ext    <= 1'b0;
                                r_brk    <= 1'b0;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // Every matching table entry follows the event, so duplicates all track.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys <= {NUM_KEYS{ACTIVE_LOW}};
        end else if (ev_valid) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (KEY_CODES[9*i +: 9] == {ev_ext, ev_code}) begin
                    keys[i] <= ACTIVE_LOW ? ev_break : ~ev_break;
                end
            end
        end
    end

endmodule
`default_nettype wire
